// File: rtl/lc3_mem_seq.sv
// Sequences LC-3 MAR/MDR strobes for one read/write request; replies with a one-cycle resp pulse (optional wait-timeout error).
// Latency: accept edge to resp_valid is 3 edges minimum, plus one per RAM wait cycle; req_ready is high only while idle.
module lc3_mem_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] resp_rdata,
    output logic [15:0] bus_out,
    output logic        bus_drive,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        mio_en,
    output logic        r_w,
    output logic        gate_mdr,
    input  logic        mem_ready,
    input  logic [15:0] mem_out
);

    typedef enum logic [2:0] {
        IDLE, LD_ADDR, LD_DATA, WR_WAIT, RD_WAIT, RD_GATE, RESP
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_q, err_nxt;
    logic [15:0]      rdata_nxt;
    logic [15:0]      addr_q, wdata_q;
    logic             write_q;
    logic             timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            err_q      <= 1'b0;
            resp_rdata <= 16'h0000;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            write_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            err_q      <= err_nxt;
            resp_rdata <= rdata_nxt;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                write_q <= req_write;
            end
        end
    end

    // mem_ready is checked ahead of timeout so a completing access always wins.
    assign timeout = TO_EN && !mem_ready && (cnt == TO_LAST);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        err_nxt    = err_q;
        rdata_nxt  = resp_rdata;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        bus_out    = 16'h0000;
        bus_drive  = 1'b0;
        ld_mar     = 1'b0;
        ld_mdr     = 1'b0;
        mio_en     = 1'b0;
        r_w        = 1'b0;
        gate_mdr   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = LD_ADDR;
                    err_nxt   = 1'b0;
                end
            end
            LD_ADDR: begin
                bus_drive = 1'b1;
                bus_out   = addr_q;
                ld_mar    = 1'b1;
                state_nxt = write_q ? LD_DATA : RD_WAIT;
            end
            LD_DATA: begin
                bus_drive = 1'b1;
                bus_out   = wdata_q;
                ld_mdr    = 1'b1;
                state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                mio_en = 1'b1;
                r_w    = 1'b1;
                if (mem_ready || timeout) begin
                    state_nxt = RESP;
                    err_nxt   = !mem_ready;
                    rdata_nxt = 16'h0000;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD_WAIT: begin
                mio_en = 1'b1;
                ld_mdr = mem_ready;
                if (mem_ready) begin
                    state_nxt = RD_GATE;
                end else if (timeout) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                    rdata_nxt = 16'h0000;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD_GATE: begin
                gate_mdr  = 1'b1;
                rdata_nxt = mem_out;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                cnt_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3_mem_seq.sv
// Directed bench for lc3_mem_seq: inputs change on the falling edge, outputs sampled 1 ns later.
module tb_lc3_mem_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_out = 16'h0000;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_rdata, bus_out;
    logic        bus_drive, ld_mar, ld_mdr, mio_en, r_w, gate_mdr;

    int checks = 0;
    int errors = 0;

    // {bus_drive, ld_mar, ld_mdr, mio_en, r_w, gate_mdr}
    wire [5:0] strb = {bus_drive, ld_mar, ld_mdr, mio_en, r_w, gate_mdr};

    lc3_mem_seq #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .bus_out(bus_out), .bus_drive(bus_drive), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .mio_en(mio_en), .r_w(r_w), .gate_mdr(gate_mdr),
        .mem_ready(mem_ready), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({strb, bus_out, resp_valid, resp_err, resp_rdata} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: strb=%b bus_out=%h rv=%b re=%b rdata=%h, need all 0",
                     strb, bus_out, resp_valid, resp_err, resp_rdata);
        end
        @(negedge clk) rst = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b resp_valid=%b, need 1/0", req_ready, resp_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({strb, bus_out, resp_valid} !== 23'h0) begin
            errors++;
            $display("FAIL reset_idle: strb=%b bus_out=%h rv=%b, need 0", strb, bus_out, resp_valid);
        end
        @(negedge clk) rst = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_release: req_ready=%b, need 1", req_ready);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h3000; req_wdata = 16'h1234; mem_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_accept: req_ready=%b, need 1", req_ready);
        end
        @(negedge clk) req_valid = 1'b0;
        #1;
        checks++;
        if (strb !== 6'b110000 || bus_out !== 16'h3000) begin
            errors++;
            $display("FAIL wr_ld_addr: strb=%b bus_out=%h, need 110000/3000", strb, bus_out);
        end
        step();
        checks++;
        if (strb !== 6'b101000 || bus_out !== 16'h1234) begin
            errors++;
            $display("FAIL wr_ld_data: strb=%b bus_out=%h, need 101000/1234", strb, bus_out);
        end
        step();
        checks++;
        if (strb !== 6'b000110 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait: strb=%b rv=%b, need 000110/0", strb, resp_valid);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h0000 || strb !== 6'b0) begin
            errors++;
            $display("FAIL wr_resp: rv=%b re=%b rdata=%h strb=%b, need 1/0/0000/000000",
                     resp_valid, resp_err, resp_rdata, strb);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done: rv=%b req_ready=%b, need 0/1", resp_valid, req_ready);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_read_wait();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3000; mem_ready = 1'b0; mem_out = 16'hDEAD;
        @(negedge clk) req_valid = 1'b0;
        #1;
        checks++;
        if (strb !== 6'b110000 || bus_out !== 16'h3000) begin
            errors++;
            $display("FAIL rd_ld_addr: strb=%b bus_out=%h, need 110000/3000", strb, bus_out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (strb !== 6'b000100 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rd_wait%0d: strb=%b rv=%b, need 000100/0", i, strb, resp_valid);
            end
        end
        @(negedge clk) mem_ready = 1'b1;
        #1;
        checks++;
        if (strb !== 6'b001100) begin
            errors++;
            $display("FAIL rd_wait_ready: strb=%b, need 001100", strb);
        end
        @(negedge clk) begin mem_ready = 1'b0; mem_out = 16'h1234; end
        #1;
        checks++;
        if (strb !== 6'b000001 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_gate: strb=%b rv=%b, need 000001/0", strb, resp_valid);
        end
        @(negedge clk) mem_out = 16'hDEAD;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h1234 || strb !== 6'b0) begin
            errors++;
            $display("FAIL rd_resp: rv=%b re=%b rdata=%h strb=%b, need 1/0/1234/000000",
                     resp_valid, resp_err, resp_rdata, strb);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL rd_hold: rv=%b rdata=%h, need 0/1234", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3002; mem_ready = 1'b0;
        @(negedge clk) req_valid = 1'b0;
        #1;
        checks++;
        if (strb !== 6'b110000 || bus_out !== 16'h3002) begin
            errors++;
            $display("FAIL to_ld_addr: strb=%b bus_out=%h, need 110000/3002", strb, bus_out);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (strb !== 6'b000100 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL to_wait%0d: strb=%b rv=%b, need 000100/0", i, strb, resp_valid);
            end
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 16'h0000 || mio_en !== 1'b0) begin
            errors++;
            $display("FAIL to_resp: rv=%b re=%b rdata=%h mio_en=%b, need 1/1/0000/0",
                     resp_valid, resp_err, resp_rdata, mio_en);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL to_done: rv=%b re=%b req_ready=%b, need 0/0/1", resp_valid, resp_err, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h4000; req_wdata = 16'hBEEF;
        mem_ready = 1'b1; mem_out = 16'h5555;
        @(negedge clk) begin req_write = 1'b0; req_addr = 16'h4001; req_wdata = 16'h0000; end
        #1;
        if (resp_valid) pulses++;
        checks++;
        if (req_ready !== 1'b0 || strb !== 6'b110000 || bus_out !== 16'h4000) begin
            errors++;
            $display("FAIL b2b_ld_addr: rdy=%b strb=%b bus_out=%h, need 0/110000/4000", req_ready, strb, bus_out);
        end
        step();
        if (resp_valid) pulses++;
        checks++;
        if (req_ready !== 1'b0 || strb !== 6'b101000 || bus_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL b2b_ld_data: rdy=%b strb=%b bus_out=%h, need 0/101000/beef", req_ready, strb, bus_out);
        end
        step();
        if (resp_valid) pulses++;
        checks++;
        if (req_ready !== 1'b0 || strb !== 6'b000110) begin
            errors++;
            $display("FAIL b2b_wr_wait: rdy=%b strb=%b, need 0/000110", req_ready, strb);
        end
        step();
        if (resp_valid) pulses++;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_wr_resp: rdy=%b rv=%b re=%b, need 0/1/0", req_ready, resp_valid, resp_err);
        end
        step();
        if (resp_valid) pulses++;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: req_ready=%b, need 1", req_ready);
        end
        @(negedge clk) req_valid = 1'b0;
        #1;
        if (resp_valid) pulses++;
        checks++;
        if (strb !== 6'b110000 || bus_out !== 16'h4001) begin
            errors++;
            $display("FAIL b2b_rd_addr: strb=%b bus_out=%h, need 110000/4001", strb, bus_out);
        end
        step();
        if (resp_valid) pulses++;
        checks++;
        if (strb !== 6'b001100) begin
            errors++;
            $display("FAIL b2b_rd_wait: strb=%b, need 001100", strb);
        end
        step();
        if (resp_valid) pulses++;
        step();
        if (resp_valid) pulses++;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_rd_resp: rv=%b rdata=%h, need 1/5555", resp_valid, resp_rdata);
        end
        step();
        if (resp_valid) pulses++;
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d resp pulses, need 2", pulses);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3004; mem_ready = 1'b0;
        @(negedge clk) req_valid = 1'b0;
        step();
        checks++;
        if (strb !== 6'b000100) begin
            errors++;
            $display("FAIL rst_pre_wait: strb=%b, need 000100", strb);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (strb !== 6'b0 || bus_out !== 16'h0000 || resp_valid !== 1'b0 || resp_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_async: strb=%b bus_out=%h rv=%b rdata=%h, need 0", strb, bus_out, resp_valid, resp_rdata);
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || strb !== 6'b0) begin
                errors++;
                $display("FAIL rst_no_resp%0d: rv=%b rdy=%b strb=%b, need 0/1/000000", i, resp_valid, req_ready, strb);
            end
        end
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h3006; mem_ready = 1'b1; mem_out = 16'h0A0B;
        @(negedge clk) req_valid = 1'b0;
        #1;
        checks++;
        if (strb !== 6'b110000 || bus_out !== 16'h3006) begin
            errors++;
            $display("FAIL rst_rd_addr: strb=%b bus_out=%h, need 110000/3006", strb, bus_out);
        end
        step();
        step();
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h0A0B) begin
            errors++;
            $display("FAIL rst_rd_resp: rv=%b re=%b rdata=%h, need 1/0/0a0b", resp_valid, resp_err, resp_rdata);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_seq.md
Name: lc3_mem_seq

Overview:
Memory access sequencer that sits directly upstream of the LC-3 MAR/MDR memory stage. It accepts single read/write requests from the control unit over a valid/ready handshake. It generates the ld_mar, ld_mdr, mio_en, r_w and gate_mdr strobes, plus the data-bus drive, in the correct order, and waits on the RAM ready signal. It returns read data or write completion as a one-cycle response pulse, with an optional wait-timeout error.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive wait cycles with mem_ready low before abort; 0 = no timeout
CNT_W, 8, wait counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_write  input  1  1 = write, 0 = read
req_addr  input  16  word address
req_wdata  input  16  write data
req_ready  output  1  request accepted on edge where req_valid & req_ready
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid: timeout abort
resp_rdata  output  16  read data, valid with resp_valid
bus_out  output  16  value driven onto data bus
bus_drive  output  1  bus_out is valid/driving
ld_mar  output  1  load MAR from bus
ld_mdr  output  1  load MDR (from RAM if mio_en, else bus)
mio_en  output  1  RAM chip select
r_w  output  1  1 = write, 0 = read
gate_mdr  output  1  MDR gated onto mem_out
mem_ready  input  1  RAM access complete
mem_out  input  16  MDR value from memory stage

Behaviour:
- States: IDLE, LD_ADDR, LD_DATA, WR_WAIT, RD_WAIT, RD_GATE, RESP.
- Reset (async, immediate): state IDLE, wait counter 0, resp_rdata 0. Internal addr/wdata regs are 0. All strobes are 0, bus_out 0, bus_drive 0, resp_valid/resp_err 0.
- Reset mid-operation aborts at once. No response is issued for the aborted request.
- req_ready = 1 only in IDLE. On an accept edge: latch req_addr, req_wdata, req_write; go to LD_ADDR.
- LD_ADDR: bus_drive=1, bus_out=addr, ld_mar=1. Next state is LD_DATA if write, else RD_WAIT.
- LD_DATA: bus_drive=1, bus_out=wdata, ld_mdr=1, mio_en=0. Next state WR_WAIT.
- WR_WAIT: mio_en=1, r_w=1.
  - mem_ready=1 -> RESP, err=0.
  - Otherwise counter+1.
- RD_WAIT: mio_en=1, r_w=0, ld_mdr=mem_ready (Mealy), so MDR loads RAM data on the completing edge.
  - mem_ready=1 -> RD_GATE.
  - Otherwise counter+1.
- Timeout, both wait states: if TIMEOUT_CYCLES!=0 and mem_ready=0 with counter==TIMEOUT_CYCLES-1 -> RESP with err=1. mio_en deasserts in RESP.
  - mem_ready wins over timeout on the same edge.
- RD_GATE: gate_mdr=1. resp_rdata <= mem_out on exit edge. Next state RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_err as recorded. Counter cleared. Next state IDLE.
  - resp_rdata is 0x0000 on error or on write; otherwise it holds until the next response.
- All strobes except RD_WAIT ld_mdr are Moore decodes of state.
- Outside the listed states: bus_out=0, bus_drive=0, strobes 0.
- Minimum latency: accept edge E0 to resp_valid high after E3, for both read and write. Each wait cycle adds one.
- req_valid held continuously: the next request is accepted in the IDLE cycle after RESP. Minimum request spacing is 5 cycles.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Reset: assert rst=0 mid-idle -> all outputs 0, req_ready=1 after release.
- Write 0x3000<=0x1234, mem_ready=1 immediately. Required sequence:
  - ld_mar with bus_out=0x3000.
  - then ld_mdr, mio_en=0, bus_out=0x1234.
  - then mio_en=1, r_w=1.
  - resp_valid=1, err=0 after E3.
- Read 0x3000, RAM model returns 0x1234 after 3 wait cycles -> ld_mdr pulses only on the mem_ready cycle, then gate_mdr. resp_valid after E6 with resp_rdata=0x1234, err=0.
- TIMEOUT_CYCLES=4, read with mem_ready stuck 0 -> exactly 4 RD_WAIT cycles, then resp_valid=1, resp_err=1, resp_rdata=0x0000, mio_en=0 in RESP.
- req_valid held high with write then read queued -> req_ready low throughout first op. Second request accepted the cycle after the first resp_valid. Exactly one resp_valid pulse per request.
- rst=0 during RD_WAIT -> mio_en/strobes drop asynchronously, no resp_valid. A following read completes normally with correct data.
